accum_datapath: RTL

- Datapath slave to the controller FSM.
- Holds the accumulator (Acc), the general register (Reg), the program counter (PC), the instruction register (IR) and the Z/C flags.
- Executes the per-cycle load and select strobes issued by the controller.
- Returns Opcode, Z and C to the controller and drives the instruction-memory address.

---
 rtl/accum_datapath.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/accum_datapath.sv
// -----------------------------------------------------------------------------
// accum_datapath
//   Datapath slave of the accumulator-machine controller. Holds the
//   accumulator (Acc), general register (Reg), program counter (PC),
//   instruction register (IR) and the Z/C flags. It executes the per-cycle
//   load/select strobes from the controller and returns Opcode/Z/C.
//
//   Optional build macro: DP_OVF_FLAG_EN
//     When defined, adds output V. V is the signed overflow of ADD/SUB,
//     captured on ALU loads of Acc. Other ALU ops clear V on such loads.
//     When undefined, port V and its logic are absent.
//
// Ports
//   CLK      in   system clock, all state changes on posedge
//   CLB      in   synchronous active-high reset, overrides every strobe
//   SelALU   in   [3:0] ALU operation select
//   SelAcc   in   [1:0] Acc source: x1=ALU, 10=Reg, 00=immediate
//   LoadAcc  in   Acc <= selected source (Z always, C on ALU loads)
//   LoadReg  in   Reg <= Acc (pre-edge value)
//   LoadPC   in   PC <= branch target (priority over IncPC)
//   SelPC    in   branch target: 0=Reg, 1=immediate
//   IncPC    in   PC <= PC+1 (wrapping)
//   LoadIR   in   IR <= InstrIn
//   InstrIn  in   [IMM_W+3:0] instruction word for the current PCAddr
//   PCAddr   out  [ADDR_W-1:0] current PC
//   Opcode   out  [3:0] upper four IR bits
//   V        out  overflow flag (DP_OVF_FLAG_EN builds only)
//   Z        out  zero flag
//   C        out  carry flag
// -----------------------------------------------------------------------------
module accum_datapath #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 4
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic [3:0]        SelALU,
  input  logic [1:0]        SelAcc,
  input  logic              LoadAcc,
  input  logic              LoadReg,
  input  logic              LoadPC,
  input  logic              SelPC,
  input  logic              IncPC,
  input  logic              LoadIR,
  input  logic [IMM_W+3:0]  InstrIn,
  output logic [ADDR_W-1:0] PCAddr,
  output logic [3:0]        Opcode,
`ifdef DP_OVF_FLAG_EN
  output logic              V,
`endif
  output logic              Z,
  output logic              C
);

  localparam int INSTR_W = IMM_W + 4;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b1100;
  localparam logic [3:0] ALU_SHL = 4'b1011;

  logic [DATA_W-1:0]  acc_r;
  logic [DATA_W-1:0]  reg_r;
  logic [ADDR_W-1:0]  pc_r;
  logic [INSTR_W-1:0] ir_r;
  logic               z_r;
  logic               c_r;

  logic [DATA_W-1:0]  imm_acc_s;
  logic [ADDR_W-1:0]  imm_pc_s;
  logic [ADDR_W-1:0]  reg_pc_s;
  logic [DATA_W-1:0]  alu_res_s;
  logic               alu_c_s;
  logic [DATA_W-1:0]  acc_next_s;
  logic [ADDR_W-1:0]  pc_next_s;

  // Immediate and Reg are zero-extended or truncated to the width of their
  // destination; only the matching generate branch is elaborated.
  if (IMM_W >= DATA_W) begin : g_imm_acc_trunc
    assign imm_acc_s = ir_r[DATA_W-1:0];
  end else begin : g_imm_acc_ext
    assign imm_acc_s = {{(DATA_W-IMM_W){1'b0}}, ir_r[IMM_W-1:0]};
  end

  if (IMM_W >= ADDR_W) begin : g_imm_pc_trunc
    assign imm_pc_s = ir_r[ADDR_W-1:0];
  end else begin : g_imm_pc_ext
    assign imm_pc_s = {{(ADDR_W-IMM_W){1'b0}}, ir_r[IMM_W-1:0]};
  end

  if (DATA_W >= ADDR_W) begin : g_reg_pc_trunc
    assign reg_pc_s = reg_r[ADDR_W-1:0];
  end else begin : g_reg_pc_ext
    assign reg_pc_s = {{(ADDR_W-DATA_W){1'b0}}, reg_r};
  end

  // ALU: combinational on current Acc (A) and Reg (B); unknown codes pass A
  // through and leave the carry as it is.
  always_comb begin
    alu_res_s = acc_r;
    alu_c_s   = c_r;
    case (SelALU)
      ALU_ADD: {alu_c_s, alu_res_s} = {1'b0, acc_r} + {1'b0, reg_r};
      // Subtract as A + ~B + 1 so the carry-out means "no borrow".
      ALU_SUB: {alu_c_s, alu_res_s} = {1'b0, acc_r} + {1'b0, ~reg_r}
                                      + {{DATA_W{1'b0}}, 1'b1};
      ALU_NOR: begin
        alu_res_s = ~(acc_r | reg_r);
        alu_c_s   = 1'b0;
      end
      ALU_SHR: begin
        alu_res_s = {1'b0, acc_r[DATA_W-1:1]};
        alu_c_s   = acc_r[0];
      end
      ALU_SHL: begin
        alu_res_s = {acc_r[DATA_W-2:0], 1'b0};
        alu_c_s   = acc_r[DATA_W-1];
      end
      default: begin
        alu_res_s = acc_r;
        alu_c_s   = c_r;
      end
    endcase
  end

  // Acc source select: bit 0 set picks the ALU regardless of bit 1.
  always_comb begin
    acc_next_s = imm_acc_s;
    case (SelAcc)
      2'b01, 2'b11: acc_next_s = alu_res_s;
      2'b10:        acc_next_s = reg_r;
      2'b00:        acc_next_s = imm_acc_s;
      default:      acc_next_s = imm_acc_s;
    endcase
  end

  // Next PC: branch load beats increment, otherwise hold.
  always_comb begin
    if (LoadPC) begin
      if (SelPC) begin
        pc_next_s = imm_pc_s;
      end else begin
        pc_next_s = reg_pc_s;
      end
    end else if (IncPC) begin
      pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Architectural state update; Reg takes the pre-edge Acc so a combined
  // LoadAcc/LoadReg with SelAcc=10 swaps the two registers.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      acc_r <= {DATA_W{1'b0}};
      reg_r <= {DATA_W{1'b0}};
      pc_r  <= {ADDR_W{1'b0}};
      ir_r  <= {INSTR_W{1'b0}};
      z_r   <= 1'b0;
      c_r   <= 1'b0;
    end else begin
      if (LoadAcc) begin
        acc_r <= acc_next_s;
        z_r   <= (acc_next_s == {DATA_W{1'b0}});
        if (SelAcc[0]) begin
          c_r <= alu_c_s;
        end
      end
      if (LoadReg) begin
        reg_r <= acc_r;
      end
      if (LoadIR) begin
        ir_r <= InstrIn;
      end
      pc_r <= pc_next_s;
    end
  end

`ifdef DP_OVF_FLAG_EN
  logic alu_v_s;
  logic v_r;

  // Signed overflow: ADD when operand signs match and the result sign
  // differs; SUB when operand signs differ and the result sign leaves A's.
  always_comb begin
    alu_v_s = 1'b0;
    case (SelALU)
      ALU_ADD: alu_v_s = (acc_r[DATA_W-1] == reg_r[DATA_W-1]) &&
                         (alu_res_s[DATA_W-1] != acc_r[DATA_W-1]);
      ALU_SUB: alu_v_s = (acc_r[DATA_W-1] != reg_r[DATA_W-1]) &&
                         (alu_res_s[DATA_W-1] != acc_r[DATA_W-1]);
      default: alu_v_s = 1'b0;
    endcase
  end

  // Overflow flag register, updated only on ALU loads of Acc.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      v_r <= 1'b0;
    end else if (LoadAcc && SelAcc[0]) begin
      v_r <= alu_v_s;
    end else begin
      v_r <= v_r;
    end
  end

  assign V = v_r;
`endif

  assign PCAddr = pc_r;
  assign Opcode = ir_r[INSTR_W-1:IMM_W];
  assign Z      = z_r;
  assign C      = c_r;

endmodule
